// File: rtl/wall_rect_writer_if.sv
// -----------------------------------------------------------------------------
// wall_rect_writer_if
// Bundles the rectangle edit request handshake and the wall bitmap RAM row port
// used by wall_rect_writer.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready is high only while the writer is idle;
// req_valid while req_ready is low is ignored. done pulses for one cycle when
// the accepted request has finished (including empty/invalid requests).
//
// RAM port: mem_rd_en with mem_addr reads a row; mem_rdata is valid the
// following cycle. mem_we with mem_addr/mem_wdata writes a row on the clock
// edge. mem_rd_en and mem_we are never high together.
//
// Modports:
//   master : environment side (requester + RAM), drives request and read data
//   slave  : the writer, drives ready/done and the RAM control/write data
// -----------------------------------------------------------------------------
interface wall_rect_writer_if #(
    parameter int H_RES  = 640,
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] rect_x0;
    logic [ADDR_W-1:0] rect_y0;
    logic [ADDR_W-1:0] rect_x1;
    logic [ADDR_W-1:0] rect_y1;
    logic [1:0]        op;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [H_RES-1:0]  mem_rdata;
    logic              mem_we;
    logic [H_RES-1:0]  mem_wdata;

    modport master (
        output req_valid, rect_x0, rect_y0, rect_x1, rect_y1, op, mem_rdata,
        input  req_ready, done, mem_addr, mem_rd_en, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, rect_x0, rect_y0, rect_x1, rect_y1, op, mem_rdata,
        output req_ready, done, mem_addr, mem_rd_en, mem_we, mem_wdata
    );
endinterface

// File: rtl/wall_rect_writer.sv
// -----------------------------------------------------------------------------
// wall_rect_writer
// Applies rectangle edits (set / clear, optionally toggle) to the row-organised
// wall bitmap RAM. Each row word holds one screen line, bit N = column N. Every
// row of the rectangle is updated with a read-modify-write over the RAM's
// synchronous port: one READ cycle, then one WRITE cycle.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   bus        wall_rect_writer_if.slave (request handshake + RAM row port)
//   state_dbg  current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 DONE)
//
// Build option:
//   WALL_TOGGLE_EN  when defined, op 2'b10 toggles the rectangle pixels.
//                   When undefined, op 2'b10 is handled like the reserved
//                   op 2'b11: accepted, done next cycle, no RAM access.
// -----------------------------------------------------------------------------
module wall_rect_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    wall_rect_writer_if.slave         bus,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(V_RES - 1);

    state_t            state;
    state_t            state_next;

    // Latched, clamped request. row_q is the row counter and also drives
    // mem_addr directly, so the address is always a register output.
    logic [ADDR_W-1:0] x0_q;
    logic [ADDR_W-1:0] x1_q;
    logic [ADDR_W-1:0] y1_q;
    logic [ADDR_W-1:0] row_q;
    logic [1:0]        op_q;

    logic [ADDR_W-1:0] x1_clamp;
    logic [ADDR_W-1:0] y1_clamp;
    logic              op_ok;
    logic              req_skip;
    logic              accept;

    logic [H_RES-1:0]  mask;
    logic [H_RES-1:0]  row_new;

    logic              req_ready;
    logic              done;
    logic              rd_en;
    logic              we;
    logic [H_RES-1:0]  wdata;

    assign x1_clamp = (bus.rect_x1 > X_MAX) ? X_MAX : bus.rect_x1;
    assign y1_clamp = (bus.rect_y1 > Y_MAX) ? Y_MAX : bus.rect_y1;

    always_comb begin
        case (bus.op)
            2'b00, 2'b01: op_ok = 1'b1;
`ifdef WALL_TOGGLE_EN
            2'b10:        op_ok = 1'b1;
`endif
            default:      op_ok = 1'b0;
        endcase
    end

    // Requests that would touch nothing (or use an unsupported op) complete
    // through DONE without any RAM cycle.
    assign req_skip = !op_ok
                   || (bus.rect_x0 > x1_clamp)
                   || (bus.rect_y0 > y1_clamp)
                   || (bus.rect_x0 > X_MAX)
                   || (bus.rect_y0 > Y_MAX);

    assign accept = bus.req_valid && (state == IDLE);

    // Columns x0..x1 inclusive: ones from bit x0 upward, ANDed with ones from
    // bit x1 downward. x1_q is already clamped to X_MAX, so the shift is safe.
    assign mask = ({H_RES{1'b1}} << x0_q) & ({H_RES{1'b1}} >> (X_MAX - x1_q));

    always_comb begin
        case (op_q)
            2'b01:   row_new = bus.mem_rdata | mask;
`ifdef WALL_TOGGLE_EN
            2'b10:   row_new = bus.mem_rdata ^ mask;
`endif
            default: row_new = bus.mem_rdata & ~mask;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        we         = 1'b0;
        wdata      = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = req_skip ? DONE : READ;
                end
            end
            READ: begin
                rd_en      = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                we         = 1'b1;
                wdata      = row_new;
                state_next = (row_q == y1_q) ? DONE : READ;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch and row counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q  <= '0;
            x1_q  <= '0;
            y1_q  <= '0;
            row_q <= '0;
            op_q  <= 2'b00;
        end else if (accept) begin
            x0_q <= bus.rect_x0;
            x1_q <= x1_clamp;
            y1_q <= y1_clamp;
            op_q <= bus.op;
            if (!req_skip) begin
                row_q <= bus.rect_y0;
            end
        end else if (state == WRITE && row_q != y1_q) begin
            // Stops at y1 (<= V_RES-1), so the counter never wraps.
            row_q <= row_q + ADDR_W'(1);
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.done      = done;
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_we    = we;
    assign bus.mem_wdata = wdata;
    assign bus.mem_addr  = row_q;
    assign state_dbg     = state;

endmodule

// File: doc/wall_rect_writer.md
Name: wall_rect_writer

Overview:
- Write-side counterpart to the per-pixel wall lookup.
- Accepts rectangle edit requests (set or clear wall pixels) and applies them to the wall bitmap RAM.
- The RAM is row-organised: one row word per screen line, bit N = column N.
- Performs a read-modify-write per row over the RAM's synchronous port; the pixel-lookup path reads the same RAM on its other port.

Parameters:
- H_RES, 640, row width in bits (screen columns)
- V_RES, 480, number of valid rows (screen lines)
- ADDR_W, 10, width of coordinates and RAM row address

Ports:
- Clk  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- req_valid  input  1  edit request present
- req_ready  output  1  block idle, can accept a request
- rect_x0  input  ADDR_W  left column, inclusive
- rect_y0  input  ADDR_W  top row, inclusive
- rect_x1  input  ADDR_W  right column, inclusive
- rect_y1  input  ADDR_W  bottom row, inclusive
- op  input  2  00 clear, 01 set, 10 toggle (optional feature), 11 reserved
- done  output  1  one-cycle pulse when a request completes
- mem_addr  output  ADDR_W  RAM row address
- mem_rd_en  output  1  RAM read strobe; data is returned the next cycle
- mem_rdata  input  H_RES  RAM row read data, valid one cycle after mem_rd_en
- mem_we  output  1  RAM write strobe
- mem_wdata  output  H_RES  RAM row write data

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; req_ready = 1.
  - done, mem_rd_en, mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - Reset mid-operation aborts immediately. A row already written stays written; no further writes occur.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch rect and op, then clamp: x1 = min(x1, H_RES-1), y1 = min(y1, V_RES-1).
  - If x0 > x1 or y0 > y1 after clamping, or op = 11, or x0 ≥ H_RES, or y0 ≥ V_RES: go to DONE with no RAM access.
  - Otherwise set the row counter to y0 and go to READ.
- READ (1 cycle): mem_rd_en = 1, mem_addr = row; go to WRITE.
- WRITE (1 cycle):
  - mem_we = 1, mem_addr = row.
  - mem_wdata = mem_rdata modified under mask M, where M[i] = 1 for x0 ≤ i ≤ x1.
  - clear: rdata & ~M. set: rdata | M.
  - If row == y1, go to DONE; else row + 1 and go to READ.
- DONE (1 cycle): done = 1; go to IDLE.
- req_ready is 0 in every state except IDLE. req_valid outside IDLE is ignored, and the latched request is not altered.
- Mask M is built from the latched, clamped x0/x1. Bits outside the mask equal mem_rdata unchanged.
- mem_addr is registered. mem_rd_en and mem_we are never asserted in the same cycle.
- Latency:
  - Handshake at cycle T. Row k (k = 0..N-1) is read at T+1+2k and written at T+2+2k.
  - done is at T+2N+1; req_ready returns at T+2N+2.
  - An empty or invalid request gives done at T+1.
- Rows wrap never: the counter stops at y1 (≤ V_RES-1), so no wrap past V_RES-1 or 2^ADDR_W-1.
- Back-to-back: a new request can be accepted in the first IDLE cycle after DONE.

Optional Feature:
- Macro: WALL_TOGGLE_EN.
- Defined: op = 10 is toggle, mem_wdata = rdata ^ M, with the same timing as set/clear.
- Undefined: op = 10 is treated like 11. The request is accepted, done pulses at T+1, and there are no RAM reads or writes.

Test Plan:
- Set rectangle x0=0, y0=5, x1=7, y1=5, op=01, row 5 RAM = all zeros:
  - one read and one write at addr 5;
  - wdata[7:0] = 8'hFF, other bits 0;
  - done at T+3.
- Clear rectangle x0=600, y0=10, x1=700, y1=12, op=00, rows all ones:
  - rows 10, 11 and 12 are written with bits 600..639 cleared and bits 0..599 set (x1 clamped to 639);
  - done at T+7.
- Clamp y: y0=478, y1=900, op=01:
  - exactly rows 478 and 479 are written;
  - no access at addr ≥ 480.
- Empty rect x0=20, x1=10, and separately op=11:
  - no mem_rd_en or mem_we;
  - done at T+1; req_ready high at T+2.
- Reset asserted during the WRITE of the second row of a 4-row request:
  - outputs go to reset values in the same cycle;
  - row 1 is unmodified after reset;
  - req_ready = 1 after reset deasserts.
- With WALL_TOGGLE_EN, op=10, x0=3, x1=4, row = 0x...0F:
  - wdata low byte = 0x17.
  - Without the macro: no RAM writes, and done at T+1.
